vec_irq_ctrl: RTL and testbench
===============================

# vec_irq_ctrl

Parametrised vectored priority interrupt controller, successor to the fixed 4-input interrupt system. Synchronises N_CH external requests and supports per-channel level or edge mode, a loadable enable mask, global enable and nested in-service tracking. Hands the controller a frozen vector for the program-counter mux through a pending/ack handshake.

## Interface
- N_CH, 4: number of interrupt channels; channel 0 is highest priority.
- VEC_W, 8: vector and program-counter width.
- VEC_BASE, 8'hF0: vector of channel 0.
- VEC_STRIDE, 4: vector spacing between channels.
- EDGE_MASK, {N_CH{1'b0}}: bit i = 1 makes channel i rising-edge sensitive; 0 makes it level sensitive.

- g_clk  in  1  clock; all state on rising edge.
- g_clr  in  1  asynchronous active-low reset.
- ext_int  in  N_CH  raw interrupt requests, asynchronous to g_clk.
- mask_in  in  N_CH  new mask value; 1 = channel enabled.
- mask_ld  in  1  loads mask_in into the mask register.
- i_en  in  1  global interrupt enable.
- i_ack  in  1  controller has taken the vector; one-cycle pulse.
- eoi  in  1  end of interrupt; one-cycle pulse.
- i_pending  out  1  request to controller.
- pc_out  out  VEC_W  vector; valid while i_pending = 1.
- isr_out  out  N_CH  in-service bits.

## Operation
- Each ext_int bit passes through a 2-flop synchroniser (s1, s2).
- Pending register pend[i]:
  - edge channel: set on s2 0→1, cleared on ack of channel i; a simultaneous set wins.
  - level channel: pend[i] = s2 each cycle; ack does not clear it.
- Candidate: the lowest i with pend[i] & mask[i], where i is strictly lower than the lowest set isr bit (or any i if isr = 0).
- FSM, two states:
  - IDLE: if i_en and a candidate exists, register idx = candidate, pc_out = VEC_BASE + idx*VEC_STRIDE (mod 2^VEC_W), i_pending = 1, go to REQ.
  - REQ: idx and pc_out are frozen. Mask loads, i_en deassertion, level drop and higher-priority arrivals do not alter or cancel the request. On i_ack: set isr[idx], clear pend[idx] if it is an edge channel, drop i_pending, return to IDLE.
- i_ack while in IDLE is ignored.
- eoi clears the lowest set isr bit; eoi with isr = 0 is ignored. When eoi and i_ack occur in the same cycle, eoi is applied first, then isr[idx] is set.
- mask_ld takes effect at the next edge; the mask register affects only future candidates.

## Timing
- Reset values: i_pending = 0, pc_out = 0, isr_out = 0, mask = 0 (all disabled), pend = 0, s1/s2 = 0, state IDLE.
- Latency: ext_int rises before edge 1 → s1 at e1 → s2 at e2 → pend at e3 → i_pending/pc_out at e4.
- After i_ack at edge k, i_pending is low after edge k; the earliest re-request is i_pending high after edge k+1.
- Back-to-back: a nested higher-priority request can be raised the cycle after ack.
- Reset mid-request drops i_pending and clears isr and mask immediately (asynchronous). Any edge occurring during reset is lost.

## Structure
- Package irq_pkg holds the state enum (IRQ_IDLE, IRQ_REQ) and a function vec_of(idx) implementing the base/stride arithmetic truncated to VEC_W.
- Sub-module irq_sync: per-channel 2-flop synchroniser plus rising-edge detect. Outputs s2 and a one-cycle rise pulse. Instantiated once with width N_CH.
- Priority encoding and the in-service comparison are done in the top module.

## Test plan
- Defaults, mask = 4'b1111, i_en = 1; pulse ext_int[2] (edge channel) → i_pending high 4 edges later, pc_out = 8'hF8. i_ack → isr_out = 4'b0100, i_pending low.
- ext_int = 4'b1010 (level) simultaneously → pc_out = 8'hF4. After ack, ch3 is blocked (lower priority than in-service ch1) until eoi. After eoi, pc_out = 8'hFC.
- Nesting: ch2 in service, ch0 asserted → pc_out = 8'hF0. Ack → isr_out = 4'b0101. First eoi → 4'b0100; second eoi → 4'b0000.
- In REQ for ch3, ch0 asserted and mask loaded to 0 → pc_out stays 8'hFC until ack. Afterwards no request while mask = 0.
- N_CH = 8: ch4 vector wraps to 8'h00; ch7 = 8'h0C.
- Reset asserted in REQ → i_pending = 0, pc_out = 0, isr_out = 0 immediately. With the edge source quiet after release, no request until a new edge occurs.

Source files
------------

// File: rtl/irq_pkg.sv
// irq_pkg: shared FSM states and vector arithmetic for the vectored interrupt controller
package irq_pkg;
  typedef enum logic {IRQ_IDLE, IRQ_REQ} irq_state_e;
  function automatic logic [31:0] vec_of(input logic [31:0] base, input logic [31:0] stride,
                                         input logic [31:0] idx);
    return base + idx * stride;
  endfunction
endpackage

// File: rtl/irq_sync.sv
// irq_sync: per-bit 2-flop synchroniser with a one-cycle rising-edge pulse on the synchronised value
module irq_sync #(
  parameter int W = 4
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] s2_o,
  output logic [W-1:0] rise_o
);
  logic [W-1:0] s1_q, s2_q, s3_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_q <= '0;
      s2_q <= '0;
      s3_q <= '0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end
  assign s2_o   = s2_q;
  assign rise_o = s2_q & ~s3_q;
endmodule

// File: rtl/vec_irq_ctrl.sv
// vec_irq_ctrl: vectored priority interrupt controller with level/edge channels, mask,
// nested in-service tracking and a frozen-vector pending/ack handshake
module vec_irq_ctrl
  import irq_pkg::*;
#(
  parameter int              N_CH       = 4,
  parameter int              VEC_W      = 8,
  parameter logic [VEC_W-1:0] VEC_BASE  = 8'hF0,
  parameter int              VEC_STRIDE = 4,
  parameter logic [N_CH-1:0] EDGE_MASK  = {N_CH{1'b0}}
) (
  input  logic             g_clk,
  input  logic             g_clr,
  input  logic [N_CH-1:0]  ext_int,
  input  logic [N_CH-1:0]  mask_in,
  input  logic             mask_ld,
  input  logic             i_en,
  input  logic             i_ack,
  input  logic             eoi,
  output logic             i_pending,
  output logic [VEC_W-1:0] pc_out,
  output logic [N_CH-1:0]  isr_out
);
  localparam int IW = N_CH > 1 ? $clog2(N_CH) : 1;
  irq_state_e state_q, state_d;
  logic [N_CH-1:0] s2, rise, pend_q, pend_d, mask_q, isr_q, isr_d;
  logic [IW-1:0] idx_q, idx_d, cand_idx;
  logic [VEC_W-1:0] pc_q, pc_d;
  logic [31:0] vec_full;
  logic cand_vld, blocked, ack_fire;
  irq_sync #(.W(N_CH)) u_sync (
    .clk_i (g_clk),
    .rst_ni(g_clr),
    .d_i   (ext_int),
    .s2_o  (s2),
    .rise_o(rise)
  );
  // a channel is eligible only if no in-service bit sits at or above its priority
  always_comb begin
    cand_vld = 1'b0;
    cand_idx = '0;
    blocked  = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      blocked = blocked | isr_q[i];
      if (!cand_vld && !blocked && pend_q[i] && mask_q[i]) begin
        cand_vld = 1'b1;
        cand_idx = IW'(i);
      end
    end
  end
  assign vec_full = vec_of(32'(VEC_BASE), 32'(VEC_STRIDE), 32'(cand_idx));
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    pc_d     = pc_q;
    ack_fire = 1'b0;
    if (state_q == IRQ_IDLE) begin
      if (i_en && cand_vld) begin
        state_d = IRQ_REQ;
        idx_d   = cand_idx;
        pc_d    = vec_full[VEC_W-1:0];
      end
    end else if (i_ack) begin
      state_d  = IRQ_IDLE;
      ack_fire = 1'b1;
    end
  end
  // eoi retires the lowest set bit before the acknowledged channel is marked in service
  always_comb begin
    isr_d = eoi ? isr_q & (isr_q - N_CH'(1)) : isr_q;
    if (ack_fire) isr_d[idx_q] = 1'b1;
    for (int i = 0; i < N_CH; i++)
      pend_d[i] = EDGE_MASK[i] ? rise[i] | (pend_q[i] & ~(ack_fire && idx_q == IW'(i))) : s2[i];
  end
  always_ff @(posedge g_clk or negedge g_clr) begin
    if (!g_clr) begin
      state_q <= IRQ_IDLE;
      idx_q   <= '0;
      pc_q    <= '0;
      pend_q  <= '0;
      mask_q  <= '0;
      isr_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      pc_q    <= pc_d;
      pend_q  <= pend_d;
      mask_q  <= mask_ld ? mask_in : mask_q;
      isr_q   <= isr_d;
    end
  end
  assign i_pending = state_q == IRQ_REQ;
  assign pc_out    = pc_q;
  assign isr_out   = isr_q;
endmodule

// File: tb/tb_vec_irq_ctrl.sv
// tb_vec_irq_ctrl: directed scoreboard bench for a 4-channel and an 8-channel vec_irq_ctrl
module tb_vec_irq_ctrl;
  logic clk = 1'b0, clr = 1'b0;
  logic [3:0] ext4 = '0, mask_in4 = '0, isr4;
  logic mask_ld4 = 0, ien4 = 1, ack4 = 0, eoi4 = 0, pend4;
  logic [7:0] pc4;
  logic [7:0] ext8 = '0, mask_in8 = '0, isr8, pc8;
  logic mask_ld8 = 0, ien8 = 1, ack8 = 0, eoi8 = 0, pend8;
  logic [7:0] q4[$], q8[$];
  int n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

  vec_irq_ctrl #(.N_CH(4), .EDGE_MASK(4'b0100)) u4 (
    .g_clk(clk), .g_clr(clr), .ext_int(ext4), .mask_in(mask_in4), .mask_ld(mask_ld4),
    .i_en(ien4), .i_ack(ack4), .eoi(eoi4), .i_pending(pend4), .pc_out(pc4), .isr_out(isr4));
  vec_irq_ctrl #(.N_CH(8)) u8 (
    .g_clk(clk), .g_clr(clr), .ext_int(ext8), .mask_in(mask_in8), .mask_ld(mask_ld8),
    .i_en(ien8), .i_ack(ack8), .eoi(eoi8), .i_pending(pend8), .pc_out(pc8), .isr_out(isr8));

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_req(input string tag, input bit sel);
    int k = 0;
    logic [7:0] e;
    while (!(sel ? pend8 : pend4) && k < 12) begin
      tick();
      k++;
    end
    chk({tag, "_pend"}, sel ? pend8 : pend4, 1);
    e = sel ? q8.pop_front() : q4.pop_front();
    chk({tag, "_pc"}, sel ? pc8 : pc4, e);
  endtask

  task automatic ack(input bit sel);
    if (sel) ack8 = 1; else ack4 = 1;
    tick();
    ack4 = 0;
    ack8 = 0;
  endtask

  task automatic end_irq(input bit sel);
    if (sel) eoi8 = 1; else eoi4 = 1;
    tick();
    eoi4 = 0;
    eoi8 = 0;
  endtask

  initial begin
    #2;
    chk("rst_pend", pend4, 0);
    chk("rst_pc", pc4, 0);
    chk("rst_isr", isr4, 0);
    #10 clr = 1;
    tick();
    mask_in4 = 4'hF; mask_ld4 = 1;
    mask_in8 = 8'hFF; mask_ld8 = 1;
    tick();
    mask_ld4 = 0; mask_ld8 = 0;
    // edge channel 2: exact 4-edge latency
    ext4 = 4'b0100; q4.push_back(8'hF8);
    tick(3);
    chk("lat_e3", pend4, 0);
    tick();
    wait_req("ch2", 0);
    ext4 = 0;
    ack(0);
    chk("ch2_isr", isr4, 4'b0100);
    chk("ch2_drop", pend4, 0);
    end_irq(0);
    chk("ch2_eoi", isr4, 0);
    // level ch1 and ch3 together: ch1 wins, ch3 blocked until eoi
    ext4 = 4'b1010; q4.push_back(8'hF4);
    wait_req("ch1", 0);
    ack(0);
    chk("ch1_isr", isr4, 4'b0010);
    ext4 = 4'b1000;
    tick(5);
    chk("ch3_blocked", pend4, 0);
    q4.push_back(8'hFC);
    end_irq(0);
    wait_req("ch3", 0);
    // frozen request: higher priority arrival, mask clear and i_en drop do not disturb it
    ext4 = 4'b1001; mask_in4 = 0; mask_ld4 = 1; ien4 = 0;
    tick();
    mask_ld4 = 0;
    tick(5);
    chk("frozen_pend", pend4, 1);
    chk("frozen_pc", pc4, 8'hFC);
    ien4 = 1;
    ack(0);
    chk("ch3_isr", isr4, 4'b1000);
    tick(5);
    chk("masked_none", pend4, 0);
    ext4 = 0;
    end_irq(0);
    chk("ch3_eoi", isr4, 0);
    ack(0);
    chk("idle_ack", isr4, 0);
    // nesting with back-to-back re-request the cycle after ack
    mask_in4 = 4'hF; mask_ld4 = 1;
    tick();
    mask_ld4 = 0;
    ext4 = 4'b0100; q4.push_back(8'hF8);
    wait_req("nest_ch2", 0);
    ext4 = 4'b0001;
    tick(4);
    chk("nest_frozen", pc4, 8'hF8);
    ack(0);
    chk("nest_isr2", isr4, 4'b0100);
    chk("b2b_low", pend4, 0);
    q4.push_back(8'hF0);
    tick();
    chk("b2b_high", pend4, 1);
    wait_req("nest_ch0", 0);
    ext4 = 0;
    ack(0);
    chk("nest_isr02", isr4, 4'b0101);
    tick(4);
    end_irq(0);
    chk("nest_eoi1", isr4, 4'b0100);
    end_irq(0);
    chk("nest_eoi2", isr4, 0);
    // eoi and ack in the same cycle
    ext4 = 4'b0100; q4.push_back(8'hF8);
    wait_req("sim_ch2", 0);
    ext4 = 4'b0001;
    ack(0);
    q4.push_back(8'hF0);
    wait_req("sim_ch0", 0);
    ext4 = 0;
    eoi4 = 1; ack4 = 1;
    tick();
    eoi4 = 0; ack4 = 0;
    chk("sim_isr", isr4, 4'b0001);
    tick(4);
    end_irq(0);
    chk("sim_eoi", isr4, 0);
    // asynchronous reset while in REQ with a channel in service
    ext4 = 4'b0100; q4.push_back(8'hF8);
    wait_req("rr_ch2", 0);
    ext4 = 0;
    ack(0);
    ext4 = 4'b0001; q4.push_back(8'hF0);
    wait_req("rr_ch0", 0);
    ext4 = 0;
    clr = 0;
    #1;
    chk("ar_pend", pend4, 0);
    chk("ar_pc", pc4, 0);
    chk("ar_isr", isr4, 0);
    #3 clr = 1;
    tick();
    mask_in4 = 4'hF; mask_ld4 = 1;
    mask_in8 = 8'hFF; mask_ld8 = 1;
    tick();
    mask_ld4 = 0; mask_ld8 = 0;
    tick(6);
    chk("post_rst_quiet", pend4, 0);
    ext4 = 4'b0100; q4.push_back(8'hF8);
    wait_req("post_rst_ch2", 0);
    ext4 = 0;
    ack(0);
    end_irq(0);
    // 8-channel instance: vector wrap
    ext8 = 8'h10; q8.push_back(8'h00);
    wait_req("w8_ch4", 1);
    ext8 = 0;
    ack(1);
    chk("w8_isr4", isr8, 8'h10);
    tick(4);
    end_irq(1);
    ext8 = 8'h80; q8.push_back(8'h0C);
    wait_req("w8_ch7", 1);
    ext8 = 0;
    ack(1);
    chk("w8_isr7", isr8, 8'h80);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
